// File: rtl/fifo_pkg.sv
// Shared definitions for the round-robin FIFO read arbiter: default sizes,
// the pend-based state encoding and helpers for the concatenated data bus.
package fifo_pkg;

   localparam int BITNUMBER_DEF = 8;
   localparam int NUM_FIFOS_DEF = 4;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] XFER = 1'b1;

   function automatic int srcWidth(input int numFifos);
      return (numFifos > 1) ? $clog2(numFifos) : 1;
   endfunction

   // FIFO idx occupies [idx*width +: width] of the concatenated read bus
   function automatic int sliceLsb(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first requester at or above ptr_i,
// wrapping modulo NUM_FIFOS.
module rr_priority_picker
   import fifo_pkg::*;
#(
   parameter  int NUM_FIFOS = NUM_FIFOS_DEF,
   localparam int SRCW      = srcWidth(NUM_FIFOS)
) (
   input  logic [NUM_FIFOS-1:0] req_i,
   input  logic [SRCW-1:0]      ptr_i,
   output logic [NUM_FIFOS-1:0] grant_o,
   output logic [SRCW-1:0]      idx_o,
   output logic                 valid_o
);

   logic [SRCW-1:0] cand;

   // NUM_FIFOS is a power of two, so SRCW-bit addition wraps exactly at NUM_FIFOS.
   // Walking offsets downward lets the smallest offset from ptr_i win.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      for (int k = NUM_FIFOS - 1; k >= 0; k--) begin
         cand = ptr_i + SRCW'(k);
         if (req_i[cand]) begin
            valid_o = 1'b1;
            idx_o   = cand;
         end
      end
      grant_o[idx_o] = valid_o;
   end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter draining NUM_FIFOS upstream FIFOs into one output FIFO,
// one word per grant, throttled by the output FIFO's almost-full flag.
module fifo_rr_arbiter
   import fifo_pkg::*;
#(
   parameter  int BITNUMBER = BITNUMBER_DEF,
   parameter  int NUM_FIFOS = NUM_FIFOS_DEF,
   localparam int SRCW      = srcWidth(NUM_FIFOS)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_FIFOS-1:0]           fifo_empty,
   input  logic [NUM_FIFOS*BITNUMBER-1:0] fifo_data_out,
   output logic [NUM_FIFOS-1:0]           fifo_rd,
   input  logic                           out_almost_full,
   output logic                           out_wr,
   output logic [BITNUMBER-1:0]           out_data,
   output logic [SRCW-1:0]                out_src
);

   logic [SRCW-1:0]      ptr_q, ptr_d;
   logic [0:0]           pend_q, pend_d;
   logic [SRCW-1:0]      pendSrc_q, pendSrc_d;

   logic [NUM_FIFOS-1:0] pickGrant;
   logic [SRCW-1:0]      pickIdx;
   logic                 pickValid;
   logic                 grantFire;

   logic [BITNUMBER-1:0] words [NUM_FIFOS];

   for (genvar g = 0; g < NUM_FIFOS; g++) begin : gSlice
      assign words[g] = fifo_data_out[sliceLsb(g, BITNUMBER) +: BITNUMBER];
   end

   rr_priority_picker #(
      .NUM_FIFOS (NUM_FIFOS)
   ) uPicker (
      .req_i   (~fifo_empty),
      .ptr_i   (ptr_q),
      .grant_o (pickGrant),
      .idx_o   (pickIdx),
      .valid_o (pickValid)
   );

   // Reset gates the strobe directly so no upstream word is popped while held.
   always_comb begin
      grantFire = pickValid & ~out_almost_full & ~reset;
      fifo_rd   = grantFire ? pickGrant : '0;
      ptr_d     = grantFire ? (pickIdx + SRCW'(1)) : ptr_q;
      pend_d    = grantFire ? XFER : IDLE;
      pendSrc_d = grantFire ? pickIdx : pendSrc_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q     <= '0;
         pend_q    <= IDLE;
         pendSrc_q <= '0;
      end else begin
         ptr_q     <= ptr_d;
         pend_q    <= pend_d;
         pendSrc_q <= pendSrc_d;
      end
   end

   // Upstream data appears one cycle after the read, aligned with pend_q.
   always_comb begin
      out_wr   = (pend_q == XFER);
      out_data = out_wr ? words[pendSrc_q] : '0;
      out_src  = pendSrc_q;
   end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Self-checking bench: upstream FIFOs are modelled as queues, and a
// rule-level round-robin model predicts every grant and output word.
module tb_fifo_rr_arbiter;

   localparam int NF = 4;
   localparam int BW = 8;

   logic          clk;
   logic          reset;
   logic [NF-1:0] fifo_empty;
   logic [NF*BW-1:0] fifo_data_out;
   logic [NF-1:0] fifo_rd;
   logic          out_almost_full;
   logic          out_wr;
   logic [BW-1:0] out_data;
   logic [1:0]    out_src;

   int checks = 0;
   int errors = 0;

   logic [BW-1:0] q [NF][$];
   logic [BW-1:0] upReg [NF];
   int            mPtr;
   bit            mPend;
   int            mSrc;
   logic [BW-1:0] mData;

   logic [NF-1:0] oRd;
   logic          oWr;
   logic [BW-1:0] oData;
   logic [1:0]    oSrc;

   fifo_rr_arbiter #(
      .BITNUMBER (BW),
      .NUM_FIFOS (NF)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .fifo_empty      (fifo_empty),
      .fifo_data_out   (fifo_data_out),
      .fifo_rd         (fifo_rd),
      .out_almost_full (out_almost_full),
      .out_wr          (out_wr),
      .out_data        (out_data),
      .out_src         (out_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic updateBus();
      for (int i = 0; i < NF; i++) begin
         fifo_empty[i] = (q[i].size() == 0);
         fifo_data_out[i*BW +: BW] = upReg[i];
      end
   endtask

   // One clock cycle: predict, compare mid-cycle, then advance the model at the edge.
   task automatic applyStimulus();
      int g;
      logic [NF-1:0] expRd;
      logic [BW-1:0] w;
      updateBus();
      if (reset) begin
         mPend = 1'b0;
         mPtr  = 0;
         mSrc  = 0;
      end
      g = -1;
      if (!reset && !out_almost_full) begin
         for (int k = 0; k < NF; k++) begin
            int idx;
            idx = (mPtr + k) % NF;
            if (g < 0 && q[idx].size() > 0) g = idx;
         end
      end
      #3;
      expRd = '0;
      if (g >= 0) expRd[g] = 1'b1;
      checkOutput("fifo_rd", 32'(fifo_rd), 32'(expRd));
      checkOutput("out_wr", 32'(out_wr), 32'(mPend));
      checkOutput("out_data", 32'(out_data), mPend ? 32'(mData) : 32'h0);
      if (mPend || reset) checkOutput("out_src", 32'(out_src), 32'(mSrc));
      oRd   = fifo_rd;
      oWr   = out_wr;
      oData = out_data;
      oSrc  = out_src;
      @(posedge clk);
      if (g >= 0) begin
         w        = q[g].pop_front();
         upReg[g] = w;
         mPend    = 1'b1;
         mSrc     = g;
         mData    = w;
         mPtr     = (g + 1) % NF;
      end else begin
         mPend = 1'b0;
      end
      #1;
   endtask

   initial begin
      reset           = 1'b0;
      out_almost_full = 1'b0;
      for (int i = 0; i < NF; i++) upReg[i] = '0;
      mPtr = 0; mPend = 1'b0; mSrc = 0; mData = '0;
      updateBus();
      #1;
      reset = 1'b1;

      // Reset held two cycles with every FIFO non-empty
      q[0].push_back(8'hA0); q[1].push_back(8'hB0);
      q[2].push_back(8'hC0); q[3].push_back(8'hD0);
      for (int c = 0; c < 2; c++) begin
         applyStimulus();
         checkOutput("rst_rd", 32'(oRd), 32'h0);
         checkOutput("rst_wr", 32'(oWr), 32'h0);
         checkOutput("rst_data", 32'(oData), 32'h0);
      end
      reset = 1'b0;
      applyStimulus(); checkOutput("lit_rd0", 32'(oRd), 32'h1);
      applyStimulus(); checkOutput("lit_rd1", 32'(oRd), 32'h2);
      checkOutput("lit_dA0", 32'(oData), 32'hA0);
      applyStimulus(); checkOutput("lit_rd2", 32'(oRd), 32'h4);
      checkOutput("lit_dB0", 32'(oData), 32'hB0);
      applyStimulus(); checkOutput("lit_rd3", 32'(oRd), 32'h8);
      checkOutput("lit_dC0", 32'(oData), 32'hC0);
      checkOutput("lit_sC0", 32'(oSrc), 32'h2);
      applyStimulus(); checkOutput("lit_dD0", 32'(oData), 32'hD0);
      checkOutput("lit_sD0", 32'(oSrc), 32'h3);

      // Single active FIFO drained back to back
      q[2].push_back(8'h01); q[2].push_back(8'h02); q[2].push_back(8'h03);
      applyStimulus(); checkOutput("lit_only2_rd", 32'(oRd), 32'h4);
      applyStimulus();
      applyStimulus(); checkOutput("lit_only2_d2", 32'(oData), 32'h02);
      applyStimulus(); checkOutput("lit_only2_d3", 32'(oData), 32'h03);
      checkOutput("lit_only2_s", 32'(oSrc), 32'h2);
      applyStimulus(); checkOutput("lit_only2_idle", 32'(oWr), 32'h0);

      // Almost-full rises the cycle after the FIFO 1 grant
      reset = 1'b1; applyStimulus(); reset = 1'b0;
      q[0].push_back(8'hA0); q[1].push_back(8'hB0);
      q[2].push_back(8'hC0); q[3].push_back(8'hD0);
      applyStimulus();
      applyStimulus(); checkOutput("lit_bp_rd1", 32'(oRd), 32'h2);
      out_almost_full = 1'b1;
      applyStimulus(); checkOutput("lit_bp_inflight", 32'(oData), 32'hB0);
      checkOutput("lit_bp_nord", 32'(oRd), 32'h0);
      applyStimulus();
      applyStimulus();
      out_almost_full = 1'b0;
      applyStimulus(); checkOutput("lit_bp_resume", 32'(oRd), 32'h4);
      applyStimulus();
      applyStimulus();

      // Reset in the cycle after a grant to FIFO 3
      q[3].push_back(8'h33);
      applyStimulus(); checkOutput("lit_r3_rd", 32'(oRd), 32'h8);
      q[0].push_back(8'h11); q[1].push_back(8'h22);
      reset = 1'b1;
      applyStimulus(); checkOutput("lit_r3_drop", 32'(oWr), 32'h0);
      reset = 1'b0;
      applyStimulus(); checkOutput("lit_r3_first", 32'(oRd), 32'h1);
      applyStimulus();
      applyStimulus(); checkOutput("lit_r3_d22", 32'(oData), 32'h22);

      // Empty, then FIFO 1 becomes non-empty
      applyStimulus();
      q[1].push_back(8'h55);
      applyStimulus(); checkOutput("lit_ne_rd", 32'(oRd), 32'h2);
      applyStimulus(); checkOutput("lit_ne_d", 32'(oData), 32'h55);
      checkOutput("lit_ne_s", 32'(oSrc), 32'h1);

      // Randomized traffic, backpressure and occasional resets
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < NF; i++)
            if ($urandom_range(0, 2) == 0 && q[i].size() < 6) q[i].push_back(8'($urandom));
         out_almost_full = ($urandom_range(0, 4) == 0);
         reset = ($urandom_range(0, 60) == 0);
         applyStimulus();
      end
      reset = 1'b0;
      out_almost_full = 1'b0;
      for (int c = 0; c < 30; c++) applyStimulus();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
